// File: rtl/countdown_timer_4bit_pkg.sv
// Shared definitions for the 4-bit countdown timer.
//   CNT_W   : width of the count and reload registers
//   state_t : controller state encoding (IDLE / RUN / HOLD)
package countdown_timer_4bit_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_HOLD = 2'b10
    } state_t;

endpackage

// File: rtl/countdown_timer_4bit_decrementer.sv
// Decrementer_4bit: combinational 4-bit decrement stage.
//   A    : input value
//   Anew : A - 1 (wraps 0 -> 15; callers must gate the zero case)
module Decrementer_4bit (
    input  logic [3:0] A,
    output logic [3:0] Anew
);

    assign Anew = A - 4'd1;

endmodule

// File: rtl/countdown_timer_4bit.sv
// Loadable 4-bit countdown timer with pause, expiry pulse and optional
// auto-reload. The count register feeds Decrementer_4bit; its output is
// registered back while running.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : capture load_val into count and reload; aborts a run
//   load_val   : value to load
//   start      : begin counting (honoured in IDLE with count != 0)
//   pause      : level, freezes the count during a run
//   count      : current count
//   busy       : high in RUN or HOLD
//   done       : one-cycle expiry pulse
module countdown_timer_4bit
    import countdown_timer_4bit_pkg::*;
#(
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             start,
    input  logic             pause,
    output logic [CNT_W-1:0] count,
    output logic             busy,
    output logic             done
);

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_count, w_count_nxt;
    logic [CNT_W-1:0] r_reload, w_reload_nxt;
    logic             r_done, w_done_nxt;
    logic             r_busy;
    logic [CNT_W-1:0] w_anew;
    logic             w_cnt_zero;
    logic             w_cnt_one;

    Decrementer_4bit u_dec (
        .A    (r_count),
        .Anew (w_anew)
    );

    assign w_cnt_zero = (r_count == '0);
    assign w_cnt_one  = (r_count == CNT_W'(1));

    always_comb begin
        w_state_nxt  = r_state;
        w_count_nxt  = r_count;
        w_reload_nxt = r_reload;
        w_done_nxt   = 1'b0;

        if (load) begin
            w_count_nxt  = load_val;
            w_reload_nxt = load_val;
            w_state_nxt  = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start && !w_cnt_zero)
                        w_state_nxt = ST_RUN;
                end
                ST_RUN: begin
                    if (pause) begin
                        w_state_nxt = ST_HOLD;
                    end else if (w_cnt_one) begin
                        w_done_nxt = 1'b1;
                        if (AUTO_RELOAD && (r_reload != '0)) begin
                            w_count_nxt = r_reload;
                        end else begin
                            w_count_nxt = w_anew;
                            w_state_nxt = ST_IDLE;
                        end
                    end else if (!w_cnt_zero) begin
                        w_count_nxt = w_anew;
                    end else begin
                        // Unreachable in normal use; never let the 0->15
                        // wrap of the decrementer reach the count.
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_HOLD: begin
                    // Resume edge only changes state; decrement restarts next edge.
                    if (!pause)
                        w_state_nxt = ST_RUN;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_count  <= '0;
            r_reload <= '0;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_count  <= w_count_nxt;
            r_reload <= w_reload_nxt;
            r_done   <= w_done_nxt;
            r_busy   <= (w_state_nxt != ST_IDLE);
        end
    end

    assign count = r_count;
    assign busy  = r_busy;
    assign done  = r_done;

endmodule

// File: tb/tb_countdown_timer_4bit.sv
module tb_countdown_timer_4bit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ld0, st0, pa0, ld1, st1, pa1;
    logic [3:0] lv0, lv1;
    logic [3:0] cnt0, cnt1;
    logic       busy0, done0, busy1, done1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    countdown_timer_4bit #(.AUTO_RELOAD(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .load(ld0), .load_val(lv0), .start(st0),
        .pause(pa0), .count(cnt0), .busy(busy0), .done(done0)
    );

    countdown_timer_4bit #(.AUTO_RELOAD(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .load(ld1), .load_val(lv1), .start(st1),
        .pause(pa1), .count(cnt1), .busy(busy1), .done(done1)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk0(input string tag, input logic [3:0] c, input logic b, input logic d);
        chk({tag, ".count"}, {4'h0, cnt0}, {4'h0, c});
        chk({tag, ".busy"},  {7'h0, busy0}, {7'h0, b});
        chk({tag, ".done"},  {7'h0, done0}, {7'h0, d});
    endtask

    task automatic chk1(input string tag, input logic [3:0] c, input logic b, input logic d);
        chk({tag, ".count"}, {4'h0, cnt1}, {4'h0, c});
        chk({tag, ".busy"},  {7'h0, busy1}, {7'h0, b});
        chk({tag, ".done"},  {7'h0, done1}, {7'h0, d});
    endtask

    initial begin
        rst_n = 1'b0;
        ld0 = 0; st0 = 0; pa0 = 0; lv0 = 0;
        ld1 = 0; st1 = 0; pa1 = 0; lv1 = 0;
        #2;
        chk0("reset0", 4'd0, 0, 0);
        chk1("reset1", 4'd0, 0, 0);
        cyc();
        rst_n = 1'b1;

        // Basic countdown from 4
        ld0 = 1; lv0 = 4'd4; cyc();
        chk0("load4", 4'd4, 0, 0);
        ld0 = 0; st0 = 1; cyc();
        chk0("start4", 4'd4, 1, 0);
        st0 = 0; cyc();
        chk0("run3", 4'd3, 1, 0);
        cyc(); chk0("run2", 4'd2, 1, 0);
        cyc(); chk0("run1", 4'd1, 1, 0);
        cyc(); chk0("expire4", 4'd0, 0, 1);
        cyc(); chk0("after4", 4'd0, 0, 0);

        // load and start together: load wins, start dropped
        ld0 = 1; lv0 = 4'd5; st0 = 1; cyc();
        chk0("ldst", 4'd5, 0, 0);
        ld0 = 0; st0 = 0; cyc();
        chk0("ldst_idle", 4'd5, 0, 0);

        // Pause at count 1
        ld0 = 1; lv0 = 4'd3; cyc();
        ld0 = 0; st0 = 1; cyc();
        st0 = 0; cyc();
        chk0("p_run2", 4'd2, 1, 0);
        cyc(); chk0("p_run1", 4'd1, 1, 0);
        pa0 = 1;
        for (int k = 0; k < 3; k++) begin
            cyc(); chk0("p_hold", 4'd1, 1, 0);
        end
        pa0 = 0; cyc();
        chk0("p_resume", 4'd1, 1, 0);
        cyc(); chk0("p_expire", 4'd0, 0, 1);

        // Abort mid-run with load + start
        ld0 = 1; lv0 = 4'd8; cyc();
        ld0 = 0; st0 = 1; cyc();
        st0 = 0; cyc(); cyc();
        chk0("a_run6", 4'd6, 1, 0);
        ld0 = 1; lv0 = 4'd9; st0 = 1; cyc();
        chk0("abort", 4'd9, 0, 0);
        ld0 = 0; st0 = 0; cyc();
        chk0("abort_idle", 4'd9, 0, 0);

        // start with count 0 ignored
        ld0 = 1; lv0 = 4'd0; cyc();
        ld0 = 0; st0 = 1; cyc();
        chk0("start0", 4'd0, 0, 0);
        st0 = 0; cyc();
        chk0("start0_b", 4'd0, 0, 0);

        // Load 15: done after exactly 15 edges, no wrap to 15
        ld0 = 1; lv0 = 4'd15; cyc();
        ld0 = 0; st0 = 1; cyc();
        st0 = 0;
        for (int k = 1; k <= 15; k++) begin
            cyc();
            chk0("l15", 4'(15 - k), (k != 15), (k == 15));
        end
        cyc(); chk0("l15_after", 4'd0, 0, 0);

        // Load 1: done on next edge
        ld0 = 1; lv0 = 4'd1; cyc();
        ld0 = 0; st0 = 1; cyc();
        st0 = 0; cyc();
        chk0("l1", 4'd0, 0, 1);
        cyc(); chk0("l1_after", 4'd0, 0, 0);

        // Auto-reload period 3
        ld1 = 1; lv1 = 4'd3; cyc();
        ld1 = 0; st1 = 1; cyc();
        chk1("ar_start", 4'd3, 1, 0);
        st1 = 0;
        for (int k = 1; k <= 9; k++) begin
            cyc();
            chk1("ar3", (k % 3 == 0) ? 4'd3 : 4'(3 - (k % 3)), 1'b1, (k % 3 == 0));
        end
        ld1 = 1; lv1 = 4'd2; cyc();
        chk1("ar_abort", 4'd2, 0, 0);
        ld1 = 0; cyc();
        chk1("ar_idle", 4'd2, 0, 0);

        // Auto-reload period 1: done every cycle
        ld1 = 1; lv1 = 4'd1; cyc();
        ld1 = 0; st1 = 1; cyc();
        st1 = 0;
        for (int k = 0; k < 3; k++) begin
            cyc(); chk1("ar1", 4'd1, 1, 1);
        end
        ld1 = 1; lv1 = 4'd0; cyc();
        ld1 = 0;
        chk1("ar1_stop", 4'd0, 0, 0);

        // Asynchronous reset mid-run at count 5
        ld0 = 1; lv0 = 4'd7; cyc();
        ld0 = 0; st0 = 1; cyc();
        st0 = 0; cyc(); cyc();
        chk0("r_run5", 4'd5, 1, 0);
        #2 rst_n = 1'b0;
        #1 chk0("r_async", 4'd0, 0, 0);
        cyc();
        chk0("r_hold", 4'd0, 0, 0);
        #2 rst_n = 1'b1;
        cyc();
        chk0("r_release", 4'd0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
